// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory
// port and presents {instr, pc, valid} to the decoder through an IF/ID
// register backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    // StDrop: a redirect hit an in-flight request; wait for its ack and discard it
    typedef enum logic {
        StFetch,
        StDrop
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        req_pend_q, req_pend_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        start_ok;
    logic        ack;
    logic        capture;
    logic        ifid_free;
    logic [31:0] redirect_tgt;

    // Request control: a raised request stays up until acked, whatever stall does
    always_comb begin
        start_ok     = (state_q == StFetch) && !buf_valid_q && !(valid_q && stall_i);
        imem_req_o   = rst_i && (req_pend_q || start_ok);
        imem_addr_o  = fetch_pc_q;
        ack          = imem_req_o && imem_ack_i;
        req_pend_d   = imem_req_o && !imem_ack_i;
        redirect_tgt = redirect_pc_i & ~32'h0000_0003;
        capture      = (state_q == StFetch) && ack && !redirect_i;
        ifid_free    = !valid_q || !stall_i;
    end

    // PC / state next-state: redirect during an in-flight request parks the target
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        unique case (state_q)
            StFetch: begin
                if (redirect_i) begin
                    if (imem_req_o && !imem_ack_i) begin
                        pending_pc_d = redirect_tgt;
                        state_d      = StDrop;
                    end else begin
                        fetch_pc_d = redirect_tgt;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            StDrop: begin
                if (ack) begin
                    // A redirect coinciding with the dropped ack is the newest target
                    fetch_pc_d = redirect_i ? redirect_tgt : pending_pc_q;
                    state_d    = StFetch;
                end else if (redirect_i) begin
                    pending_pc_d = redirect_tgt;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // IF/ID and skid buffer next-state: flush > redirect > buffer drain > capture
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            instr_d     = NOP_INSTR;
            buf_valid_d = 1'b0;
        end else if (redirect_i) begin
            buf_valid_d = 1'b0;
        end else if (buf_valid_q && !stall_i) begin
            instr_d     = buf_instr_q;
            pc_d        = buf_pc_q;
            valid_d     = 1'b1;
            buf_valid_d = 1'b0;
        end else if (capture) begin
            if (ifid_free) begin
                instr_d = imem_rdata_i;
                pc_d    = fetch_pc_q;
                valid_d = 1'b1;
            end else begin
                buf_instr_d = imem_rdata_i;
                buf_pc_d    = fetch_pc_q;
                buf_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StFetch;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= 32'h0;
            req_pend_q   <= 1'b0;
            buf_instr_q  <= NOP_INSTR;
            buf_pc_q     <= 32'h0;
            buf_valid_q  <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            req_pend_q   <= req_pend_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            buf_valid_q  <= buf_valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr + 0x1000_0000 as data.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic        req, ack, valid;
    logic [31:0] addr, rdata, instr, pc;
    logic        ack_en;
    int          wait_cfg;
    int          wcnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Memory model: ack after wait_cfg wait cycles when enabled
    assign ack   = ack_en && req && (wcnt >= wait_cfg);
    assign rdata = addr + 32'h1000_0000;
    always @(posedge clk) begin
        if (!req || ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    fetch_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .instr_o      (instr),
        .pc_o         (pc),
        .valid_o      (valid)
    );

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int w);
        @(negedge clk);
        rst = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
        ack_en = 1; wait_cfg = w;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
        ack_en = 1; wait_cfg = 0;
        @(negedge clk);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (instr !== 32'h13) begin bad++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req_forced: got %b want 0", req); end
        rst = 1;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL reset_first_req: got %b want 1", req); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_first_addr: got %h want 0", addr); end
    endtask

    task automatic test_stream;
        start(0);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL stream_t0_valid: got %b want 0", valid); end
        step;
        total++; if (valid !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL stream_t1: got v=%b pc=%h want v=1 pc=0", valid, pc); end
        total++; if (instr !== 32'h1000_0000) begin bad++; $display("FAIL stream_t1_instr: got %h want 10000000", instr); end
        total++; if (addr !== 32'h4) begin bad++; $display("FAIL stream_t1_addr: got %h want 4", addr); end
        step;
        total++; if (pc !== 32'h4 || instr !== 32'h1000_0004) begin bad++; $display("FAIL stream_t2: got pc=%h i=%h want pc=4 i=10000004", pc, instr); end
        total++; if (addr !== 32'h8) begin bad++; $display("FAIL stream_t2_addr: got %h want 8", addr); end
    endtask

    task automatic test_wait_states;
        start(3);
        for (int i = 0; i < 4; i++) begin
            total++; if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin bad++; $display("FAIL wait_first_%0d: got r=%b a=%h v=%b want r=1 a=0 v=0", i, req, addr, valid); end
            step;
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (req !== 1'b1 || addr !== 32'h4 || valid !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL wait_second_%0d: got r=%b a=%h v=%b pc=%h want r=1 a=4 v=1 pc=0", i, req, addr, valid, pc); end
            step;
        end
        total++; if (pc !== 32'h4 || instr !== 32'h1000_0004 || addr !== 32'h8) begin bad++; $display("FAIL wait_advance: got pc=%h i=%h a=%h want pc=4 i=10000004 a=8", pc, instr, addr); end
    endtask

    task automatic test_stall_buffer;
        start(0);
        step;
        ack_en = 0;
        #1;
        step;
        total++; if (valid !== 1'b1 || pc !== 32'h0 || req !== 1'b1 || addr !== 32'h4) begin bad++; $display("FAIL stall_pending: got v=%b pc=%h r=%b a=%h want v=1 pc=0 r=1 a=4", valid, pc, req, addr); end
        stall = 1;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL stall_no_withdraw: got %b want 1", req); end
        ack_en = 1;
        #1;
        step;
        total++; if (instr !== 32'h1000_0000 || pc !== 32'h0 || valid !== 1'b1) begin bad++; $display("FAIL stall_hold: got i=%h pc=%h v=%b want i=10000000 pc=0 v=1", instr, pc, valid); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL stall_buf_blocks_req: got %b want 0", req); end
        step;
        total++; if (instr !== 32'h1000_0000 || req !== 1'b0) begin bad++; $display("FAIL stall_hold2: got i=%h r=%b want i=10000000 r=0", instr, req); end
        stall = 0;
        #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL stall_release_req: got %b want 0", req); end
        step;
        total++; if (pc !== 32'h4 || instr !== 32'h1000_0004 || valid !== 1'b1) begin bad++; $display("FAIL stall_drain: got pc=%h i=%h v=%b want pc=4 i=10000004 v=1", pc, instr, valid); end
        total++; if (req !== 1'b1 || addr !== 32'h8) begin bad++; $display("FAIL stall_resume: got r=%b a=%h want r=1 a=8", req, addr); end
        step;
        total++; if (pc !== 32'h8) begin bad++; $display("FAIL stall_resume_pc: got %h want 8", pc); end
    endtask

    task automatic test_redirect_pending;
        start(0);
        step;
        step;
        ack_en = 0; redirect = 1; flush = 1; redirect_pc = 32'h0000_0102;
        #1;
        total++; if (req !== 1'b1 || addr !== 32'h8) begin bad++; $display("FAIL redir_pend_pre: got r=%b a=%h want r=1 a=8", req, addr); end
        step;
        redirect = 0; flush = 0;
        #1;
        total++; if (valid !== 1'b0 || instr !== 32'h13) begin bad++; $display("FAIL redir_flush: got v=%b i=%h want v=0 i=00000013", valid, instr); end
        total++; if (req !== 1'b1 || addr !== 32'h8) begin bad++; $display("FAIL redir_drop_hold: got r=%b a=%h want r=1 a=8", req, addr); end
        step;
        total++; if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0) begin bad++; $display("FAIL redir_drop_hold2: got r=%b a=%h v=%b want r=1 a=8 v=0", req, addr, valid); end
        ack_en = 1;
        #1;
        step;
        total++; if (valid !== 1'b0 || addr !== 32'h100 || req !== 1'b1) begin bad++; $display("FAIL redir_target: got v=%b a=%h r=%b want v=0 a=100 r=1", valid, addr, req); end
        step;
        total++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h1000_0100) begin bad++; $display("FAIL redir_first: got v=%b pc=%h i=%h want v=1 pc=100 i=10000100", valid, pc, instr); end
    endtask

    task automatic test_redirect_flush_ack;
        start(0);
        step;
        step;
        step;
        total++; if (req !== 1'b1 || addr !== 32'hC || ack !== 1'b1) begin bad++; $display("FAIL rfa_pre: got r=%b a=%h k=%b want r=1 a=c k=1", req, addr, ack); end
        redirect = 1; flush = 1; redirect_pc = 32'h0000_0200;
        step;
        redirect = 0; flush = 0;
        #1;
        total++; if (valid !== 1'b0 || instr !== 32'h13) begin bad++; $display("FAIL rfa_discard: got v=%b i=%h want v=0 i=00000013", valid, instr); end
        total++; if (req !== 1'b1 || addr !== 32'h200) begin bad++; $display("FAIL rfa_target: got r=%b a=%h want r=1 a=200", req, addr); end
        step;
        total++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== 32'h1000_0200) begin bad++; $display("FAIL rfa_first: got v=%b pc=%h i=%h want v=1 pc=200 i=10000200", valid, pc, instr); end
    endtask

    task automatic test_drop_last_wins;
        start(0);
        ack_en = 0; redirect = 1; redirect_pc = 32'h0000_0400;
        step;
        redirect_pc = 32'h0000_0500;
        #1;
        total++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL drop_hold: got r=%b a=%h want r=1 a=0", req, addr); end
        step;
        redirect_pc = 32'h0000_0604; ack_en = 1;
        #1;
        total++; if (ack !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL drop_ack: got k=%b a=%h want k=1 a=0", ack, addr); end
        step;
        redirect = 0;
        #1;
        total++; if (addr !== 32'h604 || valid !== 1'b0) begin bad++; $display("FAIL drop_last_wins: got a=%h v=%b want a=604 v=0", addr, valid); end
        step;
        total++; if (valid !== 1'b1 || pc !== 32'h604) begin bad++; $display("FAIL drop_first: got v=%b pc=%h want v=1 pc=604", valid, pc); end
    endtask

    task automatic test_wrap;
        start(0);
        redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        step;
        redirect = 0;
        #1;
        total++; if (addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin bad++; $display("FAIL wrap_align: got a=%h v=%b want a=fffffffc v=0", addr, valid); end
        step;
        total++; if (valid !== 1'b1 || pc !== 32'hFFFF_FFFC || instr !== 32'h0FFF_FFFC) begin bad++; $display("FAIL wrap_word: got v=%b pc=%h i=%h want v=1 pc=fffffffc i=0ffffffc", valid, pc, instr); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 0", addr); end
    endtask

    task automatic test_reset_mid_stall;
        start(0);
        step;
        ack_en = 0;
        #1;
        step;
        stall = 1; ack_en = 1;
        #1;
        step;
        total++; if (valid !== 1'b1 || req !== 1'b0) begin bad++; $display("FAIL rst_stall_pre: got v=%b r=%b want v=1 r=0", valid, req); end
        rst = 0;
        step;
        total++; if (valid !== 1'b0 || instr !== 32'h13 || pc !== 32'h0) begin bad++; $display("FAIL rst_stall_clear: got v=%b i=%h pc=%h want v=0 i=00000013 pc=0", valid, instr, pc); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_stall_req: got %b want 0", req); end
        rst = 1; stall = 0;
        #1;
        total++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL rst_stall_restart: got r=%b a=%h want r=1 a=0", req, addr); end
        step;
        total++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h1000_0000) begin bad++; $display("FAIL rst_stall_first: got v=%b pc=%h i=%h want v=1 pc=0 i=10000000", valid, pc, instr); end
    endtask

    initial begin
        rst = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
        ack_en = 0; wait_cfg = 0;
        test_reset;
        test_stream;
        test_wait_states;
        test_stall_buffer;
        test_redirect_pending;
        test_redirect_flush_ack;
        test_drop_last_wins;
        test_wrap;
        test_reset_mid_stall;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and drives a req/ack instruction-memory port.
- Presents {instr, pc, valid} in an IF/ID output register that the decoder consumes.
- Handles downstream stall, pipeline flush and branch/jump redirect, including redirects that arrive while a memory request is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on instr_o when not valid (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- stall_i  in  1  decoder/hazard unit cannot accept; hold IF/ID register.
- flush_i  in  1  kill IF/ID contents and buffered instruction.
- redirect_i  in  1  branch/jump taken; next fetch from redirect_pc_i.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request address, word aligned.
- imem_ack_i  in  1  memory completes request this cycle; data valid same cycle.
- imem_rdata_i  in  32  fetched instruction.
- instr_o  out  32  IF/ID instruction to decoder.
- pc_o  out  32  IF/ID PC of instr_o.
- valid_o  out  1  instr_o/pc_o hold a live instruction.

Behaviour:
- Reset (rst_i==0 at clock edge):
  - fetch_pc=RESET_PC, state=FETCH.
  - valid_o=0, instr_o=NOP_INSTR, pc_o=0.
  - Skid buffer empty; pending_pc=0.
  - imem_req_o forced 0 combinationally while rst_i==0.
  - Reset mid-transaction abandons it; the memory must tolerate a dropped request.
- Memory protocol:
  - A transaction completes in a cycle with imem_req_o && imem_ack_i.
  - Once raised, imem_req_o and imem_addr_o stay stable until ack.
  - Minimum latency is 0 wait cycles (ack in the same cycle as req).
- Request start: a new request starts only if state==FETCH, the skid buffer is empty, and !(valid_o && stall_i). A request already pending is never withdrawn by stall.
- Ack in FETCH with no redirect/flush in the same cycle:
  - Data goes to the IF/ID register if it is free (!valid_o || !stall_i); otherwise to the skid buffer (buf_instr, buf_pc, buf_valid=1).
  - fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - Fetch-to-valid_o latency is one clock after the ack.
- Stall release: when stall_i==0 and buf_valid, the IF/ID register loads from the buffer and buf_valid clears.
- Hold: while stall_i && valid_o, instr_o/pc_o/valid_o hold.
- Flush (flush_i=1):
  - Next edge: valid_o=0, instr_o=NOP_INSTR, buf_valid=0.
  - Flush has priority over stall and over ack data.
  - An ack in the same cycle is discarded; fetch_pc still advances unless redirected.
- Redirect (redirect_i=1):
  - Discards same-cycle ack data and the skid buffer.
  - If no request is pending, or ack arrives this cycle: fetch_pc=redirect_pc_i&~3, state stays FETCH.
  - If a request is pending without ack: pending_pc=redirect_pc_i&~3, state=DROP.
  - Redirect does not itself clear valid_o; the hazard unit asserts flush_i with it.
- DROP state:
  - Keeps imem_req_o=1 at the old address until ack; the ack data is discarded.
  - On ack: fetch_pc=pending_pc, state=FETCH.
  - A further redirect in DROP overwrites pending_pc (last one wins); if it coincides with the ack, the new target is used.
- Priority: reset > flush > redirect > stall > normal.

Test Plan:
- Reset, then ack every cycle, stall=0 -> imem_addr_o 0x0,0x4,0x8; valid_o rises one cycle after first ack; pc_o tracks 0x0,0x4 with 1-cycle lag.
- Ack with 3 wait cycles per request -> imem_addr_o stable 0x4 for 4 cycles; valid_o/pc_o advance only after ack; no double capture.
- Stall while a request is pending, ack arrives during stall -> instr_o held, ack data enters buffer, no new req; stall drop -> instr_o shows buffered word next cycle, then fetching resumes at next PC.
- Redirect to 0x0000_0102 while request at 0x8 pending -> req held at 0x8 until ack, data discarded, next req at 0x100, valid_o never shows the 0x8 word (flush asserted with redirect).
- Redirect+flush coincident with ack of 0xC -> 0xC word discarded, valid_o=0 next cycle, next req at target.
- Assert rst_i=0 mid-stall with buffer full -> next cycle valid_o=0, instr_o=0x00000013, req at RESET_PC after release.
